// File: rtl/icache_sa.sv
// Parametrised set-associative instruction cache with multi-beat refill and whole-cache flush.
// Optional hit/miss counters are built in when ICACHE_SA_STATS_EN is defined.
module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data
`ifdef ICACHE_SA_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - OW - IW;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_nxt;

  logic [WAYS-1:0][SETS-1:0] valid;
  logic [TW-1:0]             tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0]         data_mem [WAYS][SETS][LINE_WORDS];
  logic [WW-1:0]             rr       [SETS];

  logic [ADDR_W-1:0] base;
  logic [IW-1:0]     ref_set;
  logic [WW-1:0]     ref_way;
  logic [OW-1:0]     beat;
  logic              drop;

  logic [OW-1:0]   off;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic [WAYS-1:0] match;
  logic [WW-1:0]   hit_way, victim;
  logic            lookup, hit, miss, last_beat;

  assign off = addr_in[OW-1:0];
  assign idx = addr_in[OW+IW-1:OW];
  assign tag = addr_in[ADDR_W-1:OW+IW];

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[w][idx] && (tag_mem[w][idx] == tag);
      if (match[w]) hit_way = WW'(w);
    end
  end

  // Prefer the lowest invalid way; fall back to the set's round-robin pointer.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = rr[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w][idx] && !found) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
  end

  assign lookup    = (state == IDLE) && req_valid && !flush;
  assign hit       = lookup && (|match);
  assign miss      = lookup && !(|match);
  assign ready     = hit;
  assign data_out  = hit ? data_mem[hit_way][idx][off] : '0;
  assign mem_req   = (state == REFILL);
  assign mem_addr  = mem_req ? base + ADDR_W'(beat) : '0;
  assign last_beat = mem_req && mem_valid && (beat == OW'(LINE_WORDS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss) state_nxt = REFILL;
      REFILL:  if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      valid   <= '0;
      base    <= '0;
      ref_set <= '0;
      ref_way <= '0;
      beat    <= '0;
      drop    <= 1'b0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        base    <= {addr_in[ADDR_W-1:OW], OW'(0)};
        ref_set <= idx;
        ref_way <= victim;
        beat    <= '0;
      end
      if (mem_req && mem_valid) begin
        data_mem[ref_way][ref_set][beat] <= mem_data;
        beat <= beat + 1'b1;
      end
      if (last_beat) begin
        tag_mem[ref_way][ref_set] <= base[ADDR_W-1:OW+IW];
        if (!drop && !flush) valid[ref_way][ref_set] <= 1'b1;
        rr[ref_set] <= (WAYS > 1) ? rr[ref_set] + 1'b1 : '0;
      end
      if (flush) valid <= '0;
      // A flush landing mid-refill must keep the in-flight line from going valid.
      if (mem_req) begin
        if (last_beat)  drop <= 1'b0;
        else if (flush) drop <= 1'b1;
      end
    end
  end

  assert property (@(posedge clock) disable iff (!reset) $onehot0(match));

`ifdef ICACHE_SA_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != '1))   hit_count  <= hit_count + 1'b1;
      if (miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: 2 ways, 4 sets, 4-word lines, latency-2 memory model.
module tb_icache_sa;
  logic        clock = 1'b0;
  logic        reset, req_valid, flush, mem_valid;
  logic [29:0] addr_in, mem_addr;
  logic [31:0] data_out, mem_data;
  logic        ready, mem_req;
`ifdef ICACHE_SA_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_data[$];
  logic [29:0] exp_beat[$];

  icache_sa #(.WAYS(2), .SETS(4), .LINE_WORDS(4), .ADDR_W(30), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .addr_in(addr_in), .flush(flush),
    .data_out(data_out), .ready(ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data)
`ifdef ICACHE_SA_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  assign mem_data = {2'b00, mem_addr} ^ 32'hA5A5_0000;

  // Memory model: mem_valid in the third cycle each beat address is shown.
  initial begin
    int cnt;
    cnt = 0;
    mem_valid = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!mem_req) begin cnt = 0; mem_valid = 1'b0; end
      else if (mem_valid) begin mem_valid = 1'b0; cnt = 1; end
      else if (cnt == 2) mem_valid = 1'b1;
      else cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected hit data and expected beat addresses.
  always @(negedge clock) begin
    if (reset === 1'b1 && ready === 1'b1) begin
      if (exp_data.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_hit actual=0x%08h expected=none", data_out);
      end else chk("hit_data", data_out, exp_data.pop_front());
    end
    if (reset === 1'b1 && mem_req === 1'b1 && mem_valid === 1'b1) begin
      if (exp_beat.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat actual=0x%08h expected=none", mem_addr);
      end else chk("beat_addr", {2'b00, mem_addr}, {2'b00, exp_beat.pop_front()});
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic push_line(input logic [29:0] a);
    for (int i = 0; i < 4; i++) exp_beat.push_back({a[29:2], 2'b00} + 30'(i));
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < lim) begin @(negedge clock); n++; end
    chk("ready_reached", {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_addr(input logic [29:0] a, input int lim);
    int n;
    n = 0;
    while (mem_addr !== a && n < lim) begin @(posedge clock); #1; n++; end
    chk("addr_reached", {2'b00, mem_addr}, {2'b00, a});
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (mem_req !== 1'b0 && n < lim) begin @(posedge clock); #1; n++; end
    chk("refill_end", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic fetch_miss(input logic [29:0] a);
    push_line(a);
    exp_data.push_back({2'b00, a} ^ 32'hA5A5_0000);
    addr_in = a; req_valid = 1'b1;
    @(negedge clock);
    chk("miss_ready", {31'd0, ready}, 32'd0);
    @(negedge clock);
    chk("miss_req", {31'd0, mem_req}, 32'd1);
    chk("miss_addr0", {2'b00, mem_addr}, {4'd0, a[29:2], 2'b00});
    wait_ready(100);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic fetch_hit(input logic [29:0] a);
    exp_data.push_back({2'b00, a} ^ 32'hA5A5_0000);
    addr_in = a; req_valid = 1'b1;
    @(negedge clock);
    chk("hit_ready", {31'd0, ready}, 32'd1);
    chk("hit_no_req", {31'd0, mem_req}, 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("hit_no_refill", {31'd0, mem_req}, 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0; addr_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Cold miss, then a hit in the same line.
    fetch_miss(30'h10);
    fetch_hit(30'h13);

    // Flush in IDLE: no hit, no refill, line gone afterwards.
    addr_in = 30'h13; req_valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    chk("idle_flush_ready", {31'd0, ready}, 32'd0);
    @(posedge clock); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    chk("idle_flush_no_req", {31'd0, mem_req}, 32'd0);
    @(posedge clock); #1;
    fetch_miss(30'h13);

    // Associativity and round-robin replacement in set 0.
    do_reset();
    fetch_miss(30'h00);
    fetch_miss(30'h40);
    fetch_hit(30'h00);
    fetch_hit(30'h40);
    fetch_miss(30'h80);
    fetch_hit(30'h40);
    fetch_miss(30'h00);
    fetch_hit(30'h80);
    fetch_hit(30'h00);
    fetch_miss(30'h40);

    // Flush during the second beat of a refill.
    do_reset();
    fetch_miss(30'h10);
    push_line(30'h20);
    addr_in = 30'h20; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_addr(30'h21, 50);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    wait_idle(50);
    fetch_miss(30'h20);
    fetch_miss(30'h10);

    // Reset during the third beat abandons the refill.
    exp_beat.push_back(30'h60);
    exp_beat.push_back(30'h61);
    addr_in = 30'h60; req_valid = 1'b1;
    @(posedge clock); #1;
    wait_addr(30'h62, 50);
    do_reset();
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd0);
    fetch_miss(30'h60);

    // Address change mid-refill: 0x30 completes, then 0x54 refills.
    push_line(30'h30);
    push_line(30'h54);
    exp_data.push_back(32'hA5A5_0054);
    addr_in = 30'h30; req_valid = 1'b1;
    @(negedge clock);
    chk("chg_miss_ready", {31'd0, ready}, 32'd0);
    @(posedge clock); #1;
    addr_in = 30'h54;
    wait_addr(30'h54, 60);
    wait_ready(100);
    @(posedge clock); #1;
    req_valid = 1'b0;
    fetch_hit(30'h30);
    fetch_hit(30'h60);
    fetch_hit(30'h57);

    repeat (5) @(posedge clock);
    chk("data_queue_drained", exp_data.size(), 32'd0);
    chk("beat_queue_drained", exp_beat.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
